dmem_interface: RTL
===================

Name: dmem_interface

Overview:
- Memory-stage data-memory port for the 5-stage MIPS pipeline.
- Consumes the M-stage address (aluoutM), store data (writedataM) and memory control.
- Runs a req/ready handshake to a variable-latency data memory and stalls the pipeline until the access completes.
- Returns load data to the M→W pipeline register; load-byte selection stays in W.

Parameters:
- TIMEOUT, 255: REQ-state cycles without mem_ready before the access is abandoned.
- CNTW, 8: timeout counter width; must satisfy 2^CNTW > TIMEOUT.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- memreadM  in  1  load in M stage
- memwriteM  in  1  store in M stage
- sbM  in  1  store is sb (byte); ignored unless memwriteM
- aluoutM  in  32  effective byte address
- writedataM  in  32  store data
- readdataM  out  32  load data, captured from memory
- stallM  out  1  freeze PC/F/D/E/M registers this cycle
- mem_req  out  1  request valid (registered)
- mem_we  out  1  1 = write
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables
- mem_ready  in  1  memory completes the request this cycle
- mem_rdata  in  32  read data, valid with mem_ready
- err  out  1  sticky timeout flag
- misalign  out  1  sticky misaligned word-access flag (see Optional Feature)

Behaviour:
- Reset (sync, on the clk edge with reset=1): state IDLE, all outputs 0, counter 0, err=0, misalign=0. Applies mid-access: mem_req drops on the same edge and the in-flight access is discarded.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If memreadM|memwriteM, stallM=1 combinationally.
  - Latch mem_addr, mem_we=memwriteM, mem_wdata and mem_be.
  - Next state REQ; mem_req=1 from next cycle.
  - With no op, stallM=0.
- REQ:
  - mem_req=1 and stallM=1.
  - mem_addr, mem_we, mem_wdata and mem_be stay stable until mem_ready.
  - On mem_ready=1: for reads, capture mem_rdata into readdataM. Next state DONE; mem_req=0 next cycle.
  - Counter increments each REQ cycle without ready.
  - At counter==TIMEOUT: drop the request, set err=1, readdataM=0, next state DONE.
- DONE:
  - stallM=0 for exactly one cycle so the pipeline advances.
  - M-stage op inputs are ignored in this cycle, so the same instruction is not relaunched.
  - Next state IDLE; counter cleared.
- readdataM holds its value until the next read completion. Stores do not modify it.
- Minimum cost per access: op seen at cycle t, mem_ready at t+1, DONE at t+2. That is 2 stall cycles, and the instruction leaves M at the end of t+2.
- Byte enables and write data:
  - Word access (loads, sw): mem_be=4'hF, mem_wdata=writedataM.
  - sb: mem_be=4'b0001<<aluoutM[1:0]; mem_wdata={4{writedataM[7:0]}}.
- memreadM and memwriteM both high: treated as a write.
- err clears only on reset. Subsequent accesses proceed normally.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined:
  - A word access (load or sw) with aluoutM[1:0]!=0 issues no mem_req.
  - The FSM goes IDLE→DONE directly: stallM=1 for 1 cycle, misalign=1 (sticky until reset), readdataM unchanged.
  - sb is never misaligned.
- Undefined: misalign tied 0; aluoutM[1:0] ignored for word accesses, and the word at {addr[31:2],00} is accessed.

Test Plan:
- lw, aluoutM=0x0000_1004, mem_ready high on first REQ cycle with mem_rdata=0xCAFE_F00D → mem_addr=0x1004, mem_be=F, mem_we=0; stallM high 2 cycles; readdataM=0xCAFE_F00D in DONE.
- sb, aluoutM=0x0000_2003, writedataM=0x1234_56AB, 3-cycle memory latency → mem_be=1000, mem_wdata=0xABAB_ABAB, mem_addr=0x2000; request fields stable all 3 REQ cycles; stallM high 4 cycles.
- Back-to-back lw then sw in consecutive M slots → second request starts in the cycle after DONE; no duplicate request for the first instruction.
- TIMEOUT=4, mem_ready held 0 → mem_req drops after 4 REQ cycles; err=1; readdataM=0; pipeline released; next access completes normally with err still 1.
- reset pulsed during REQ → mem_req=0, stallM=0, state IDLE on the next edge; a later lw at 0x10 completes normally.
- With MISALIGN_CHECK_EN, lw at 0x0000_0006 → no mem_req; stallM=1 for one cycle; misalign=1. Without the macro → mem_addr=0x0000_0004, misalign=0.

Source files
------------

// File: rtl/dmem_if.sv
// Data-memory request/response bus between the M-stage port and a variable-latency memory.
interface dmem_if;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/dmem_interface.sv
// M-stage data-memory port: req/ready handshake with pipeline stall and timeout.
// Optional macro MISALIGN_CHECK_EN: reject misaligned word accesses without a memory request.
module dmem_interface #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNTW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memreadM,
  input  logic          memwriteM,
  input  logic          sbM,
  input  logic [31:0]   aluoutM,
  input  logic [31:0]   writedataM,
  output logic [31:0]   readdataM,
  output logic          stallM,
  output logic          err,
  output logic          misalign,
  dmem_if.master        mem
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state, stateNext;
  logic [CNTW-1:0] cnt, cntNext;
  logic            reqNext, weNext, errNext, misalignNext;
  logic [31:0]     addrNext, wdataNext, rdataNext;
  logic [3:0]      beNext;
  logic            opM, byteStore, misWord;

  // A simultaneous read and write is treated as a write
  assign opM       = memreadM | memwriteM;
  assign byteStore = memwriteM & sbM;

`ifdef MISALIGN_CHECK_EN
  assign misWord = ~byteStore & (aluoutM[1:0] != 2'b00);
`else
  assign misWord = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be    <= '0;
      readdataM     <= '0;
      err           <= 1'b0;
      misalign      <= 1'b0;
    end else begin
      state         <= stateNext;
      cnt           <= cntNext;
      mem.mem_req   <= reqNext;
      mem.mem_we    <= weNext;
      mem.mem_addr  <= addrNext;
      mem.mem_wdata <= wdataNext;
      mem.mem_be    <= beNext;
      readdataM     <= rdataNext;
      err           <= errNext;
      misalign      <= misalignNext;
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    reqNext      = mem.mem_req;
    weNext       = mem.mem_we;
    addrNext     = mem.mem_addr;
    wdataNext    = mem.mem_wdata;
    beNext       = mem.mem_be;
    rdataNext    = readdataM;
    errNext      = err;
    misalignNext = misalign;
    stallM       = 1'b0;

    case (state)
      IDLE: begin
        if (opM) begin
          stallM = 1'b1;
          if (misWord) begin
            misalignNext = 1'b1;
            stateNext    = DONE;
          end else begin
            reqNext   = 1'b1;
            weNext    = memwriteM;
            addrNext  = {aluoutM[31:2], 2'b00};
            wdataNext = byteStore ? {4{writedataM[7:0]}} : writedataM;
            beNext    = byteStore ? 4'(4'b0001 << aluoutM[1:0]) : 4'hF;
            stateNext = REQ;
          end
        end
      end
      REQ: begin
        stallM = 1'b1;
        if (mem.mem_ready) begin
          if (!mem.mem_we) rdataNext = mem.mem_rdata;
          reqNext   = 1'b0;
          stateNext = DONE;
        end else if (cnt == CNTW'(TIMEOUT - 1)) begin
          // Abandon after TIMEOUT request cycles without ready
          reqNext   = 1'b0;
          errNext   = 1'b1;
          rdataNext = '0;
          stateNext = DONE;
        end else begin
          cntNext = cnt + CNTW'(1);
        end
      end
      DONE: begin
        cntNext   = '0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    if (reset) stallM = 1'b0;
  end

endmodule
